// File: rtl/req_encoder_4to2.sv
// Registered 4-to-2 encoder for active-low request lines, with a valid/ready grant handshake.
// Define REQ_ENCODER_ROUND_ROBIN_EN for round-robin selection; the default is highest-index priority.
module req_encoder_4to2 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_n,
  input  logic       en_n,
  output logic [1:0] code_out,
  output logic       valid,
  input  logic       ready,
  output logic [3:0] pending,
  output logic       overflow
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state, state_next;
  logic [3:0]             req_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] en_sync;
  logic [3:0]             req_prev;
  logic                   en_on;
  logic [3:0]             capture;
  logic [3:0]             clear;
  logic                   accept;
  logic                   load_code;
  logic [1:0]             sel;

  // Synchronizer and previous-sample flops idle high so a line held low
  // through reset still produces exactly one edge once reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) req_sync[s] <= '1;
      en_sync  <= '1;
      req_prev <= '1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      req_sync[0] <= req_n;
      for (int s = 1; s < SYNC_STAGES; s++) req_sync[s] <= req_sync[s-1];
      en_sync  <= {en_sync[SYNC_STAGES-2:0], en_n};
      req_prev <= req_sync[SYNC_STAGES-1];
    end
  end

  assign en_on   = ~en_sync[SYNC_STAGES-1];
  assign capture = en_on ? (req_prev & ~req_sync[SYNC_STAGES-1]) : 4'b0000;
  assign accept  = (state == GRANT) && ready;
  assign clear   = accept ? (4'b0001 << code_out) : 4'b0000;
  assign valid   = (state == GRANT);

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
  logic [1:0] last_grant;
  logic [1:0] rr_idx;
  logic       found;

  always_ff @(posedge clk) begin
    if (rst)         last_grant <= 2'd3;
    else if (accept) last_grant <= code_out;
  end

  // Search starts one past the last accepted index and wraps.
  always_comb begin
    sel    = 2'd0;
    found  = 1'b0;
    rr_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      rr_idx = last_grant + 2'(k + 1);
      if (!found && pending[rr_idx]) begin
        sel   = rr_idx;
        found = 1'b1;
      end
    end
  end
`else
  // Later (higher) indices overwrite earlier ones, so the highest pending bit wins.
  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (pending[i]) sel = 2'(i);
    end
  end
`endif

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    state_next = state;
    load_code  = 1'b0;
    case (state)
      IDLE: begin
        if ((pending != 4'b0000) && en_on) begin
          state_next = GRANT;
          load_code  = 1'b1;
        end
      end
      GRANT: begin
        if (ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A new edge on a bit being cleared this cycle keeps it pending; an edge on a
  // bit that stays pending is a lost request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      code_out <= 2'd0;
      pending  <= 4'b0000;
      overflow <= 1'b0;
    end else begin
      state    <= state_next;
      if (load_code) code_out <= sel;
      pending  <= (pending & ~clear) | capture;
      if ((capture & pending & ~clear) != 4'b0000) overflow <= 1'b1;
    end
  end

endmodule
